// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the up-counter with 7-segment readout:
//   - conv_state_t   : state encoding of the binary-to-BCD converter FSM
//   - SEG_0..SEG_9   : active-low 7-segment codes, bit order gfedcba
//   - SEG_BLANK      : all segments off
//   - BCD_W          : width of the three-digit BCD work register
//   - digit_to_seg() : BCD digit to segment code, non-decimal values blank
// -----------------------------------------------------------------------------
package contador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-add-3 (double-dabble) converter, one bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, aborts a conversion at once
//   start      sampled in IDLE; captures value and begins a conversion
//   value[N]   binary value to convert
//   busy       high in SHIFT and DONE
//   done       high for the single DONE cycle; digits are final then
//   bcd2/1/0   hundreds / tens / units BCD digits
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start; value is captured on the start edge
//   ST_SHIFT | one adjust-and-shift step per cycle, N cycles total
//   ST_DONE  | digits final for one cycle (done=1), then back to IDLE
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] value,
    output logic         busy,
    output logic         done,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0
);
    import contador_pkg::*;

    localparam int CW = $clog2(N + 1);

    conv_state_t          state;
    logic [N-1:0]         bin_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [CW-1:0]        steps_left;

    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W+N-1:0]   shifted;
    logic [BCD_W-1:0]     bcd_n;
    logic [N-1:0]         bin_n;

    // Every digit >= 5 gets +3 before the shift so it carries correctly
    // into the next decade after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
        bcd_n   = shifted[BCD_W+N-1:N];
        bin_n   = shifted[N-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            steps_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_q      <= value;
                        bcd_q      <= '0;
                        steps_left <= CW'(N - 1);
                        busy       <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bin_q <= bin_n;
                    bcd_q <= bcd_n;
                    if (steps_left == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        steps_left <= steps_left - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd2 = bcd_q[11:8];
    assign bcd1 = bcd_q[7:4];
    assign bcd0 = bcd_q[3:0];

endmodule

// File: rtl/contador_ascendente.sv
// -----------------------------------------------------------------------------
// contador_ascendente
// Edge-triggered up-counter with wrap pulse and a three-digit active-low
// 7-segment readout refreshed by a sequential binary-to-BCD converter.
//
// Parameters:
//   N      counter width, 1..9
//   LIMIT  highest count before wrapping to 0, LIMIT <= 2**N-1
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   initial_value  loaded into count while reset is high
//   inc            increment request, counted once per rising edge
//   count          current counter value
//   wrap           one-cycle pulse in the cycle count shows 0 after wrapping
//   busy           conversion in progress
//   seg2/seg1/seg0 hundreds/tens/units, active low, bit order gfedcba
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zeros on seg2/seg1 are
//                          blanked; seg0 always shows its digit.
// -----------------------------------------------------------------------------
module contador_ascendente #(
    parameter int N     = 6,
    parameter int LIMIT = 2**N - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] initial_value,
    input  logic         inc,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         busy,
    output logic [6:0]   seg2,
    output logic [6:0]   seg1,
    output logic [6:0]   seg0
);
    import contador_pkg::*;

    localparam logic [N-1:0] LIMIT_V = N'(LIMIT);

    logic         inc_q;
    logic         inc_evt;
    logic [N-1:0] snapshot;
    logic         snap_valid;
    logic         conv_start;
    logic         conv_done;
    logic [3:0]   d2, d1, d0;
    logic [6:0]   seg2_n, seg1_n, seg0_n;

    assign inc_evt = inc & ~inc_q;

    // inc_q resets high so an inc already asserted at reset release is
    // treated as old, not as a fresh edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q <= 1'b1;
            count <= initial_value;
            wrap  <= 1'b0;
        end else begin
            inc_q <= inc;
            wrap  <= 1'b0;
            if (inc_evt) begin
                // >= also catches an out-of-range initial_value.
                if (count >= LIMIT_V) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // The snapshot is what the converter is (or last was) working on; a new
    // conversion is only launched from IDLE, so a change mid-conversion is
    // picked up once the current one finishes.
    assign conv_start = ~busy & (~snap_valid | (count != snapshot));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot   <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (conv_start) begin
                snapshot <= count;
            end
            if (conv_done) begin
                snap_valid <= 1'b1;
            end
        end
    end

    bin_to_bcd_seq #(
        .N (N)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .value (count),
        .busy  (busy),
        .done  (conv_done),
        .bcd2  (d2),
        .bcd1  (d1),
        .bcd0  (d0)
    );

    always_comb begin
        seg2_n = digit_to_seg(d2);
        seg1_n = digit_to_seg(d1);
        seg0_n = digit_to_seg(d0);
`ifdef LEADING_ZERO_BLANK_EN
        if (d2 == 4'd0) begin
            seg2_n = SEG_BLANK;
            if (d1 == 4'd0) begin
                seg1_n = SEG_BLANK;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg2 <= SEG_BLANK;
            seg1 <= SEG_BLANK;
            seg0 <= SEG_BLANK;
        end else if (conv_done) begin
            seg2 <= seg2_n;
            seg1 <= seg1_n;
            seg0 <= seg0_n;
        end
    end

endmodule

// File: tb/tb_contador_ascendente.sv
module tb_contador_ascendente;

    localparam int N     = 6;
    localparam int LIMIT = 63;

    logic         clk = 1'b0;
    logic         reset;
    logic         inc;
    logic [N-1:0] initial_value;
    logic [N-1:0] count;
    logic         wrap;
    logic         busy;
    logic [6:0]   seg2, seg1, seg0;

    always #5 clk = ~clk;

    contador_ascendente #(
        .N     (N),
        .LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .initial_value (initial_value),
        .inc           (inc),
        .count         (count),
        .wrap          (wrap),
        .busy          (busy),
        .seg2          (seg2),
        .seg1          (seg1),
        .seg0          (seg0)
    );

    typedef struct {
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        int         v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int   h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        e.v  = v;
        e.s2 = enc(h);
        e.s1 = enc(t);
        e.s0 = enc(u);
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) begin
            e.s2 = BLANK;
            if (t == 0) e.s1 = BLANK;
        end
`endif
        return e;
    endfunction

    // Scoreboard monitor: each completed conversion (busy falling outside
    // reset) pops one expected readout and checks digits and busy length.
    logic busy_prev = 1'b0;
    int   busy_run  = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_prev) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL conv_unexpected: got segs %b %b %b, required no conversion", seg2, seg1, seg0);
            end else begin
                mon_e = sb.pop_front();
                if ({seg2, seg1, seg0} !== {mon_e.s2, mon_e.s1, mon_e.s0})
                    $display("FAIL conv_segs(%0d): got %b %b %b, required %b %b %b",
                             mon_e.v, seg2, seg1, seg0, mon_e.s2, mon_e.s1, mon_e.s0);
                else
                    n_pass++;
                n_checks++;
                if (busy_run !== N + 1)
                    $display("FAIL conv_busy_len(%0d): got %0d, required %0d", mon_e.v, busy_run, N + 1);
                else
                    n_pass++;
            end
            busy_run = 0;
        end
        busy_prev = busy;
    end

    task automatic drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL drain_%s: got %0d pending conversions, required 0", tag, sb.size());
        else
            n_pass++;
    endtask

    task automatic apply_reset(input int init);
        @(negedge clk);
        reset         = 1'b1;
        initial_value = N'(init);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.push_back(model(init));
    endtask

    task automatic test_reset();
        int   lat;
        exp_t e;
        reset = 1'b1; inc = 1'b0; initial_value = 6'd5;
        repeat (3) @(negedge clk);
        n_checks++; if (count !== 6'd5) $display("FAIL rst_count: got %0d, required 5", count); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL rst_wrap: got %b, required 0", wrap); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
        n_checks++;
        if ({seg2, seg1, seg0} !== {BLANK, BLANK, BLANK})
            $display("FAIL rst_segs: got %b %b %b, required all 1111111", seg2, seg1, seg0);
        else n_pass++;
        e = model(5);
        sb.push_back(e);
        reset = 1'b0;
        lat = 0;
        while ({seg2, seg1, seg0} !== {e.s2, e.s1, e.s0} && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat !== N + 2) $display("FAIL rst_first_latency: got %0d, required %0d", lat, N + 2); else n_pass++;
        n_checks++; if (seg0 !== 7'b0010010) $display("FAIL rst_seg0_five: got %b, required 0010010", seg0); else n_pass++;
        drain("reset");
    endtask

    task automatic test_inc_high_at_reset();
        @(negedge clk);
        reset = 1'b1; inc = 1'b1; initial_value = 6'd20;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.push_back(model(20));
        repeat (3) @(negedge clk);
        n_checks++; if (count !== 6'd20) $display("FAIL inc_high_release: got %0d, required 20", count); else n_pass++;
        inc = 1'b0;
        drain("inc_high");
    endtask

    task automatic test_single_inc();
        int   lat;
        exp_t e;
        apply_reset(9);
        drain("single_pre");
        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        n_checks++; if (count !== 6'd10) $display("FAIL single_count: got %0d, required 10", count); else n_pass++;
        e = model(10);
        sb.push_back(e);
        lat = 0;
        while ({seg2, seg1, seg0} !== {e.s2, e.s1, e.s0} && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat !== N + 2) $display("FAIL single_latency: got %0d, required %0d", lat, N + 2); else n_pass++;
        n_checks++; if (seg1 !== 7'b1111001) $display("FAIL single_seg1: got %b, required 1111001", seg1); else n_pass++;
        n_checks++; if (seg0 !== 7'b1000000) $display("FAIL single_seg0: got %b, required 1000000", seg0); else n_pass++;
        drain("single");
    endtask

    task automatic test_inc_held();
        @(negedge clk); inc = 1'b1;
        sb.push_back(model(11));
        repeat (20) @(negedge clk);
        n_checks++; if (count !== 6'd11) $display("FAIL held_count: got %0d, required 11", count); else n_pass++;
        inc = 1'b0;
        drain("held");
        n_checks++; if (count !== 6'd11) $display("FAIL held_count_after: got %0d, required 11", count); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset(62);
        drain("wrap_pre");
        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        n_checks++; if (count !== 6'd63) $display("FAIL wrap_count63: got %0d, required 63", count); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL wrap_early: got %b, required 0", wrap); else n_pass++;
        sb.push_back(model(63));
        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        n_checks++; if (count !== 6'd0) $display("FAIL wrap_count0: got %0d, required 0", count); else n_pass++;
        n_checks++; if (wrap !== 1'b1) $display("FAIL wrap_pulse: got %b, required 1", wrap); else n_pass++;
        sb.push_back(model(0));
        @(negedge clk);
        n_checks++; if (wrap !== 1'b0) $display("FAIL wrap_width: got %b, required 0", wrap); else n_pass++;
        drain("wrap");
    endtask

    task automatic test_back_to_back();
        apply_reset(40);
        drain("b2b_pre");
        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        n_checks++; if (count !== 6'd41) $display("FAIL b2b_count41: got %0d, required 41", count); else n_pass++;
        sb.push_back(model(41));
        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        n_checks++; if (count !== 6'd42) $display("FAIL b2b_count42: got %0d, required 42", count); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b, required 1", busy); else n_pass++;
        sb.push_back(model(42));
        drain("b2b");
    endtask

    task automatic test_abort();
        int   lat;
        exp_t e;
        exp_t dropped;
        @(negedge clk); inc = 1'b1;
        @(negedge clk); inc = 1'b0;
        sb.push_back(model(43));
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b, required 1", busy); else n_pass++;
        initial_value = 6'd17;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy_drop: got %b, required 0", busy); else n_pass++;
        n_checks++;
        if ({seg2, seg1, seg0} !== {BLANK, BLANK, BLANK})
            $display("FAIL abort_segs: got %b %b %b, required all 1111111", seg2, seg1, seg0);
        else n_pass++;
        n_checks++; if (count !== 6'd17) $display("FAIL abort_count: got %0d, required 17", count); else n_pass++;
        dropped = sb.pop_back();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        e = model(17);
        sb.push_back(e);
        lat = 0;
        while ({seg2, seg1, seg0} !== {e.s2, e.s1, e.s0} && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat !== N + 2) $display("FAIL abort_latency(%0d dropped): got %0d, required %0d", dropped.v, lat, N + 2); else n_pass++;
        drain("abort");
    endtask

    task automatic test_random();
        int v, nv;
        for (int it = 0; it < 4; it++) begin
            v  = (it == 0) ? 63 : int'($urandom_range(0, 63));
            nv = (v == LIMIT) ? 0 : v + 1;
            apply_reset(v);
            drain("rand_pre");
            @(negedge clk); inc = 1'b1;
            @(negedge clk); inc = 1'b0;
            n_checks++; if (count !== N'(nv)) $display("FAIL rand_count(%0d): got %0d, required %0d", v, count, nv); else n_pass++;
            n_checks++; if (wrap !== (v == LIMIT)) $display("FAIL rand_wrap(%0d): got %b, required %b", v, wrap, (v == LIMIT)); else n_pass++;
            sb.push_back(model(nv));
            drain("rand");
        end
    endtask

    initial begin
        test_reset();
        test_inc_high_at_reset();
        test_single_inc();
        test_inc_held();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
